// File: rtl/load_data_cache_pkg.sv
// Shared constants, state encodings and line/address layouts for the load data cache.
package load_data_cache_pkg;

  localparam int unsigned WORD_SIZE  = 32;
  localparam int unsigned INDEX_BITS = 4;
  localparam int unsigned TAG_BITS   = WORD_SIZE - INDEX_BITS;
  localparam int unsigned LINES      = 1 << INDEX_BITS;

  // Nominal main-memory fill latency in cycles; used by benches to pace mem_ack.
  localparam int unsigned FILL_LATENCY = 3;

  localparam logic [1:0] CACHE_IDLE   = 2'd0;
  localparam logic [1:0] CACHE_LOOKUP = 2'd1;
  localparam logic [1:0] CACHE_FILL   = 2'd2;
  localparam logic [1:0] CACHE_RESP   = 2'd3;

  typedef struct packed {
    logic [TAG_BITS-1:0]   tag;
    logic [INDEX_BITS-1:0] index;
  } addr_t;

  typedef struct packed {
    logic [TAG_BITS-1:0]  tag;
    logic [WORD_SIZE-1:0] data;
  } line_t;

endpackage

// File: rtl/load_cache_array.sv
// Direct-mapped valid/tag/data storage: combinational lookup, store-update port,
// fill install port and whole-array flush.
module load_cache_array
  import load_data_cache_pkg::*;
(
  input  logic                 clk,
  input  logic                 reset,
  input  logic [WORD_SIZE-1:0] lk_addr_i,
  output logic                 lk_hit_c_o,
  output logic [WORD_SIZE-1:0] lk_data_c_o,
  input  logic                 wr_en_i,
  input  logic [WORD_SIZE-1:0] wr_addr_i,
  input  logic [WORD_SIZE-1:0] wr_data_i,
  input  logic                 fill_en_i,
  input  logic [WORD_SIZE-1:0] fill_addr_i,
  input  logic [WORD_SIZE-1:0] fill_data_i,
  input  logic                 flush_i
);

  logic [LINES-1:0] valid_q, valid_d;
  line_t            lines_q [LINES];
  line_t            lines_d [LINES];

  addr_t lk_a, wr_a, fill_a;
  logic  wr_hit_c;

  assign lk_a   = addr_t'(lk_addr_i);
  assign wr_a   = addr_t'(wr_addr_i);
  assign fill_a = addr_t'(fill_addr_i);

  assign lk_hit_c_o  = valid_q[lk_a.index] && (lines_q[lk_a.index].tag == lk_a.tag);
  assign lk_data_c_o = lines_q[lk_a.index].data;

  // Write-no-allocate: stores only touch a resident line with a matching tag.
  assign wr_hit_c = wr_en_i && valid_q[wr_a.index] && (lines_q[wr_a.index].tag == wr_a.tag);

  // Priority: flush > fill install > store update.
  always_comb begin
    valid_d = valid_q;
    lines_d = lines_q;
    if (wr_hit_c) begin
      lines_d[wr_a.index].data = wr_data_i;
    end
    if (fill_en_i) begin
      lines_d[fill_a.index].tag  = fill_a.tag;
      lines_d[fill_a.index].data = fill_data_i;
      valid_d[fill_a.index]      = 1'b1;
    end
    if (flush_i) begin
      valid_d = '0;
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      valid_q <= '0;
    end else begin
      valid_q <= valid_d;
    end
  end

  // Tag/data need no reset: every line is invalid until filled.
  always_ff @(posedge clk) begin
    lines_q <= lines_d;
  end

endmodule

// File: rtl/load_data_cache.sv
// Load data cache top: lookup/fill FSM, fill-override on in-flight stores, memory handshake.
// Optional hit/miss counters are built when LOAD_DATA_CACHE_STATS_EN is defined.
module load_data_cache
  import load_data_cache_pkg::*;
(
  input  logic                 clk,
  input  logic                 reset,
  input  logic                 rd_en,
  input  logic [WORD_SIZE-1:0] rd_addr,
  output logic                 ready,
  output logic                 rsp_valid,
  output logic [WORD_SIZE-1:0] rsp_data,
  output logic                 rsp_hit,
  input  logic                 wr_en,
  input  logic [WORD_SIZE-1:0] wr_addr,
  input  logic [WORD_SIZE-1:0] wr_data,
  input  logic                 flush,
  output logic                 mem_req,
  output logic [WORD_SIZE-1:0] mem_addr,
  input  logic                 mem_ack,
  input  logic [WORD_SIZE-1:0] mem_rdata
`ifdef LOAD_DATA_CACHE_STATS_EN
  ,
  output logic [31:0]          hit_count,
  output logic [31:0]          miss_count
`endif
);

  logic [1:0]           state_q, state_d;
  logic [WORD_SIZE-1:0] addr_q, addr_d;
  logic                 ready_q, ready_d;
  logic                 rsp_valid_q, rsp_valid_d;
  logic [WORD_SIZE-1:0] rsp_data_q, rsp_data_d;
  logic                 rsp_hit_q, rsp_hit_d;
  logic                 mem_req_q, mem_req_d;
  logic [WORD_SIZE-1:0] mem_addr_q, mem_addr_d;
  logic                 ovr_q, ovr_d;
  logic [WORD_SIZE-1:0] ovr_data_q, ovr_data_d;
  logic                 flushed_q, flushed_d;

  logic                 lk_hit_c;
  logic [WORD_SIZE-1:0] lk_data_c;
  logic                 fill_en_c;
  logic                 wr_to_miss_c;
  logic [WORD_SIZE-1:0] fill_word_c;

  load_cache_array u_array (
    .clk         (clk),
    .reset       (reset),
    .lk_addr_i   (addr_q),
    .lk_hit_c_o  (lk_hit_c),
    .lk_data_c_o (lk_data_c),
    .wr_en_i     (wr_en),
    .wr_addr_i   (wr_addr),
    .wr_data_i   (wr_data),
    .fill_en_i   (fill_en_c),
    .fill_addr_i (addr_q),
    .fill_data_i (fill_word_c),
    .flush_i     (flush)
  );

  // A store to the missing address, earlier in the fill or in the ack cycle, beats memory data.
  assign wr_to_miss_c = wr_en && (wr_addr == addr_q);
  assign fill_word_c  = wr_to_miss_c ? wr_data : (ovr_q ? ovr_data_q : mem_rdata);

  always_comb begin
    state_d     = state_q;
    addr_d      = addr_q;
    rsp_valid_d = 1'b0;
    rsp_data_d  = rsp_data_q;
    rsp_hit_d   = rsp_hit_q;
    mem_req_d   = mem_req_q;
    mem_addr_d  = mem_addr_q;
    ovr_d       = ovr_q;
    ovr_data_d  = ovr_data_q;
    flushed_d   = flushed_q;
    fill_en_c   = 1'b0;
    unique case (state_q)
      CACHE_IDLE: begin
        if (rd_en) begin
          addr_d    = rd_addr;
          ovr_d     = 1'b0;
          flushed_d = 1'b0;
          state_d   = CACHE_LOOKUP;
        end
      end
      CACHE_LOOKUP: begin
        if (lk_hit_c) begin
          rsp_valid_d = 1'b1;
          rsp_hit_d   = 1'b1;
          rsp_data_d  = lk_data_c;
          state_d     = CACHE_IDLE;
        end else begin
          mem_req_d  = 1'b1;
          mem_addr_d = addr_q;
          state_d    = CACHE_FILL;
        end
      end
      CACHE_FILL: begin
        if (mem_ack) begin
          mem_req_d   = 1'b0;
          fill_en_c   = !flushed_q;
          rsp_valid_d = 1'b1;
          rsp_hit_d   = 1'b0;
          rsp_data_d  = fill_word_c;
          state_d     = CACHE_RESP;
        end else begin
          if (wr_to_miss_c) begin
            ovr_d      = 1'b1;
            ovr_data_d = wr_data;
          end
          if (flush) begin
            flushed_d = 1'b1;
          end
        end
      end
      CACHE_RESP: begin
        state_d = CACHE_IDLE;
      end
      default: begin
        state_d = CACHE_IDLE;
      end
    endcase
    ready_d = (state_d == CACHE_IDLE);
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q     <= CACHE_IDLE;
      addr_q      <= '0;
      ready_q     <= 1'b1;
      rsp_valid_q <= 1'b0;
      rsp_data_q  <= '0;
      rsp_hit_q   <= 1'b0;
      mem_req_q   <= 1'b0;
      mem_addr_q  <= '0;
      ovr_q       <= 1'b0;
      ovr_data_q  <= '0;
      flushed_q   <= 1'b0;
    end else begin
      state_q     <= state_d;
      addr_q      <= addr_d;
      ready_q     <= ready_d;
      rsp_valid_q <= rsp_valid_d;
      rsp_data_q  <= rsp_data_d;
      rsp_hit_q   <= rsp_hit_d;
      mem_req_q   <= mem_req_d;
      mem_addr_q  <= mem_addr_d;
      ovr_q       <= ovr_d;
      ovr_data_q  <= ovr_data_d;
      flushed_q   <= flushed_d;
    end
  end

  assign ready     = ready_q;
  assign rsp_valid = rsp_valid_q;
  assign rsp_data  = rsp_data_q;
  assign rsp_hit   = rsp_hit_q;
  assign mem_req   = mem_req_q;
  assign mem_addr  = mem_addr_q;

`ifdef LOAD_DATA_CACHE_STATS_EN
  logic [31:0] hit_count_q;
  logic [31:0] miss_count_q;

  // Saturating counters, advanced alongside the response they count; flush leaves them alone.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      hit_count_q  <= '0;
      miss_count_q <= '0;
    end else if (rsp_valid_d) begin
      if (rsp_hit_d && (hit_count_q != '1)) begin
        hit_count_q <= hit_count_q + 32'(1);
      end
      if (!rsp_hit_d && (miss_count_q != '1)) begin
        miss_count_q <= miss_count_q + 32'(1);
      end
    end
  end

  assign hit_count  = hit_count_q;
  assign miss_count = miss_count_q;
`endif

endmodule

// File: doc/load_data_cache.md
Name: load_data_cache

Overview:
- Direct-mapped, word-granular data cache serving the load reservation stations' read port.
- On a read request it looks up a line; a hit returns one cycle later, a miss runs a fill handshake to main memory and then responds.
- Store commits from the reorder buffer update resident lines (write-no-allocate).
- Sits between the load RS (upstream requester) and main memory (downstream).

Parameters:
- WORD_SIZE, 32, data and address width; addresses are word addresses.
- INDEX_BITS, 4, log2 of line count (16 lines, one word per line).
- TAG_BITS, WORD_SIZE-INDEX_BITS, derived; not overridden.

Ports:
- clk  in  1  clock, rising edge.
- reset  in  1  asynchronous, active-high.
- rd_en  in  1  read request; accepted only when ready=1.
- rd_addr  in  WORD_SIZE  read word address (load RS computes Vj+Vk).
- ready  out  1  cache idle; can accept rd_en.
- rsp_valid  out  1  one-cycle pulse; rsp_data and rsp_hit are valid.
- rsp_data  out  WORD_SIZE  load result.
- rsp_hit  out  1  1 = served from cache, 0 = served via fill.
- wr_en  in  1  store commit write.
- wr_addr  in  WORD_SIZE  store address.
- wr_data  in  WORD_SIZE  store data.
- flush  in  1  invalidate all lines.
- mem_req  out  1  fill request; held until mem_ack.
- mem_addr  out  WORD_SIZE  fill address.
- mem_ack  in  1  fill data valid, single-cycle.
- mem_rdata  in  WORD_SIZE  fill data.

Behaviour:
- Address split: index = addr[INDEX_BITS-1:0], tag = addr[WORD_SIZE-1:INDEX_BITS]. Per line: valid bit, tag, data word.
- Reset (async):
  - All valid bits 0, state IDLE.
  - ready=1; rsp_valid=0, rsp_data=0, rsp_hit=0, mem_req=0, mem_addr=0.
  - Any in-flight miss is abandoned and no response is issued.
- States: IDLE, LOOKUP, FILL, RESP.
- IDLE:
  - ready=1.
  - rd_en latches rd_addr -> LOOKUP; ready drops in the same cycle.
- LOOKUP:
  - On hit (valid && tag match): drive rsp_valid=1, rsp_hit=1, rsp_data=line data -> IDLE. Hit latency is one cycle after acceptance.
  - On miss: mem_req=1, mem_addr=latched addr -> FILL.
- FILL:
  - mem_req held at 1 until mem_ack.
  - On mem_ack: install line (valid=1, tag, mem_rdata), unless a flush occurred during the fill; capture data -> RESP.
- RESP: rsp_valid=1, rsp_hit=0, rsp_data=captured word -> IDLE. Miss latency is mem_ack cycle + 1.
- rsp_valid: pulses for exactly one cycle. rsp_data holds its last value until the next response.
- Writes: accepted in any state.
  - If the line at wr_addr's index is valid with a matching tag, update data next edge.
  - On a miss the write is ignored (memory write is not this block's job).
- Write to in-flight miss address (during FILL, or in the mem_ack cycle):
  - Set override flag and store wr_data.
  - Install and respond with wr_data instead of mem_rdata.
- Write hitting the address under LOOKUP in the same cycle: the response returns the old data. The write lands after the read; the ROB orders stores after older loads.
- flush:
  - Clears all valid bits at the next edge; takes priority over a same-cycle write update and a same-cycle fill install.
  - During FILL the fill still completes and responds, but the line is not installed.
- rd_en while ready=0 is ignored; the requester must hold rd_en until it sees ready.

Optional Feature:
- Macro LOAD_DATA_CACHE_STATS_EN.
- Defined:
  - Adds outputs hit_count and miss_count (32 bits each).
  - Each increments when a response issues with rsp_hit=1 or 0 respectively.
  - Both saturate at all-ones and clear on reset; flush does not clear them.
- Undefined: ports and counters are absent; behaviour is otherwise identical.

Decomposition:
- Shared package (parameters.v): WORD_SIZE, cache state encodings (CACHE_IDLE, CACHE_LOOKUP, CACHE_FILL, CACHE_RESP), MEM_STALL-replacement fill-latency constant for benches.
- One sub-module is natural: load_cache_array. It holds the valid/tag/data storage, combinational lookup (hit, data), the write-update port and the flush clear.
- The top level holds the FSM, override logic, memory handshake and stats.

Test Plan:
- Cold read: reset, rd_addr=0x25 -> mem_req=1 with mem_addr=0x25; mem_ack with 0xDEAD after 3 cycles -> rsp_valid one cycle later, rsp_data=0xDEAD, rsp_hit=0.
- Hit: repeat rd_addr=0x25 -> rsp_valid one cycle after acceptance, rsp_data=0xDEAD, rsp_hit=1, mem_req stays 0.
- Conflict: read 0x35 (same index 5, different tag) -> miss; fill 0x1111. Then read 0x25 -> miss again (evicted).
- Write hit and override:
  - With 0x35 resident, write 0x35=0xBEEF -> next read of 0x35 hits with 0xBEEF.
  - Read 0x46 (miss) and write 0x46=0x7 during FILL; mem_ack with 0x9 -> rsp_data=0x7, and a later read of 0x46 hits with 0x7.
- Flush mid-fill: read 0x10, assert flush in FILL, mem_ack 0xAA -> rsp_data=0xAA, rsp_hit=0. Re-read 0x10 -> misses; 0x35 also misses.
- Reset mid-fill: assert reset while mem_req=1 -> mem_req=0, ready=1 immediately, no rsp_valid. With the stats macro, counters return to 0.
